// File: rtl/fifo_uart_tx.sv
`default_nettype none
// =============================================================================
// fifo_uart_tx : pops words from a show-ahead FIFO, sends them LSB-first as
// UART frames (start, data, [parity], stop). Macro FIFO_UART_TX_PARITY_EN
// inserts an even-parity bit after the data bits.
// Revision: 1.0
// =============================================================================
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "fifo_uart_tx: DATA_WIDTH must be >= 1");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  run_en;
  logic                  bit_last;
  logic                  pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity;
`endif

  assign bit_last = (clk_cnt == CNT_LAST);
  assign shifted  = shreg >> 1;

  // run_en holds off the first pop until a clock edge has been seen out of reset,
  // so the strobe never depends combinationally on rst_n.
  assign pop = run_en && !fifo_empty &&
               ((state == S_IDLE) || ((state == S_STOP) && bit_last));
  assign fifo_rd_en = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      run_en  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      run_en  <= 1'b1;
      tx_done <= 1'b0;
      if (pop) begin
        shreg   <= fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity  <= ^fifo_rd_data;
`endif
        state   <= S_START;
        tx      <= 1'b0;
        busy    <= 1'b1;
        clk_cnt <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          S_START: begin
            if (bit_last) begin
              state   <= S_DATA;
              clk_cnt <= '0;
              tx      <= shreg[0];
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (bit_last) begin
              clk_cnt <= '0;
              if (bit_idx == IDX_LAST) begin
                bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                state   <= S_PARITY;
                tx      <= parity;
`else
                state   <= S_STOP;
                tx      <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                shreg   <= shifted;
                tx      <= shifted[0];
              end
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
`ifdef FIFO_UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_last) begin
              state   <= S_STOP;
              clk_cnt <= '0;
              tx      <= 1'b1;
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
            end
          end
`endif
          S_STOP: begin
            if (bit_last) begin
              state   <= S_IDLE;
              clk_cnt <= '0;
              busy    <= 1'b0;
              tx      <= 1'b1;
            end else begin
              clk_cnt <= clk_cnt + CNT_W'(1);
              // Registered pulse lands on the final stop-bit cycle.
              if (clk_cnt == CNT_PRE) begin
                tx_done <= 1'b1;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            busy    <= 1'b0;
            tx      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
